// File: rtl/pixel_spi_tx.sv
// pixel_spi_tx: MSB-first 3-wire SPI frame transmitter; define PIXEL_SPI_TX_PARITY_EN to append an even-parity bit
module pixel_spi_tx #(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              spi_clk,
    output logic              spi_en,
    output logic              spi_data,
    output logic              busy,
    output logic              done
);
`ifdef PIXEL_SPI_TX_PARITY_EN
    localparam int N = DATA_W + 1;
`else
    localparam int N = DATA_W;
`endif
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(N);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [N-2:0]  sh_q, sh_d;
    logic [N-1:0]  load;
    logic          spi_clk_q, spi_clk_d;
    logic          spi_en_q, spi_en_d;
    logic          spi_data_q, spi_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          accept;
    logic          tick;

`ifdef PIXEL_SPI_TX_PARITY_EN
    assign load = {tx_data, ^tx_data};
`else
    assign load = tx_data;
`endif

    assign tx_ready = state_q == IDLE;
    assign accept   = tx_valid & tx_ready;
    assign tick     = cnt_q == CW'(CLK_DIV - 1);
    assign spi_clk  = spi_clk_q;
    assign spi_en   = spi_en_q;
    assign spi_data = spi_data_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // next state: the shift register holds the bits still to be sent, MSB already on spi_data
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        sh_d       = sh_q;
        spi_clk_d  = spi_clk_q;
        spi_en_d   = spi_en_q;
        spi_data_d = spi_data_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d    = SETUP;
                    bit_d      = BW'(N - 1);
                    sh_d       = load[N-2:0];
                    spi_en_d   = 1'b1;
                    spi_data_d = load[N-1];
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d   = SHIFT;
                    cnt_d     = '0;
                    spi_clk_d = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    cnt_d     = '0;
                    spi_clk_d = !spi_clk_q;
                    if (spi_clk_q && bit_q == '0) begin
                        state_d = HOLD;
                    end else if (spi_clk_q) begin
                        bit_d      = bit_q - 1'b1;
                        sh_d       = sh_q << 1;
                        spi_data_d = sh_q[N-2];
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    spi_en_d = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    // state and registered outputs; reset abandons any frame in flight
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            spi_clk_q  <= 1'b0;
            spi_en_q   <= 1'b0;
            spi_data_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            spi_clk_q  <= spi_clk_d;
            spi_en_q   <= spi_en_d;
            spi_data_q <= spi_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_pixel_spi_tx.sv
// tb_pixel_spi_tx: directed vector bench for pixel_spi_tx (honours PIXEL_SPI_TX_PARITY_EN)
module tb_pixel_spi_tx;
`ifdef PIXEL_SPI_TX_PARITY_EN
    localparam int NB     = 33;
    localparam int EN_LEN = 268;
`else
    localparam int NB     = 32;
    localparam int EN_LEN = 260;
`endif

    typedef struct {
        logic [31:0] data;
        logic        par;
    } vec_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready, spi_clk, spi_en, spi_data, busy, done;

    int n_chk = 0;
    int n_fail = 0;

    logic [63:0] rx, snap_rx;
    int          edges, en_cyc, done_n, gap, last_gap, snap_edges, snap_en;
    int          done_total = 0;
    int          viol = 0;
    logic        prev_en = 1'b0, prev_clk = 1'b0, prev_data = 1'b0;

    pixel_spi_tx #(.DATA_W(32), .CLK_DIV(4)) dut (
        .clk(clk), .nrst(nrst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .spi_clk(spi_clk), .spi_en(spi_en),
        .spi_data(spi_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // receiver model: samples on spi_clk rise, measures frame length, gaps and done pulses
    always @(negedge clk) begin
        if (spi_en && !prev_en) begin
            last_gap = gap;
            gap = 0;
            rx = '0;
            edges = 0;
            en_cyc = 0;
            done_n = 0;
        end
        if (!spi_en) gap++;
        if (spi_en) en_cyc++;
        if (spi_en && spi_clk && !prev_clk) begin
            rx = {rx[62:0], spi_data};
            edges++;
        end
        if (spi_clk && prev_clk && spi_data != prev_data) viol++;
        if (done) begin
            done_n++;
            snap_rx = rx;
            snap_edges = edges;
            snap_en = en_cyc;
            done_total++;
        end
        prev_en = spi_en;
        prev_clk = spi_clk;
        prev_data = spi_data;
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tk();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] d);
        tx_data = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 50 && !busy; i++) tk();
        check("accept_timeout", 64'(busy), 64'd1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 3000 && done_total < target; i++) tk();
        check("done_timeout", 64'(done_total >= target), 64'd1);
    endtask

    function automatic logic [63:0] exp_word(input logic [31:0] d, input logic p);
`ifdef PIXEL_SPI_TX_PARITY_EN
        return {31'b0, d, p};
`else
        return {32'b0, d} | 64'(p & 1'b0);
`endif
    endfunction

    vec_t vecs[4];
    int   bad;

    initial begin
        vecs[0] = '{32'hA5C3_0F81, 1'b0};
        vecs[1] = '{32'h8000_0001, 1'b0};
        vecs[2] = '{32'h0000_0007, 1'b1};
        vecs[3] = '{32'h5555_5555, 1'b0};

        #1;
        check("reset_outputs", 64'({tx_ready, spi_en, spi_clk, busy, done, spi_data}), 64'b100000);
        tk();
        tk();
        nrst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tk();
            check("idle_outputs", 64'({tx_ready, spi_en, spi_clk, busy, done, spi_data}), 64'b100000);
        end

        for (int v = 0; v < 4; v++) begin
            start(vecs[v].data);
            check("busy_in_frame", 64'({busy, tx_ready}), 64'b10);
            wait_done(done_total + 1);
            check("rx_word", snap_rx, exp_word(vecs[v].data, vecs[v].par));
            check("rise_edges", 64'(snap_edges), 64'(NB));
            check("en_length", 64'(snap_en), 64'(EN_LEN));
`ifdef PIXEL_SPI_TX_PARITY_EN
            check("last_bit", 64'(snap_rx[0]), 64'(vecs[v].par));
`else
            check("last_bit", 64'(snap_rx[0]), 64'(vecs[v].data[0]));
`endif
            check("done_state", 64'({done, busy, tx_ready, spi_en}), 64'b1010);
            tk();
            check("done_one_cycle", 64'({done, done_n}), 64'd1);
            for (int i = 0; i < 3; i++) tk();
        end

        begin
            int base;
            base = done_total;
            start(32'h0000_0001);
            tx_valid = 1'b1;
            tx_data = 32'hFFFF_FFFE;
            wait_done(base + 1);
            check("b2b_first", snap_rx, exp_word(32'h0000_0001, 1'b1));
            for (int i = 0; i < 10 && !busy; i++) tk();
            tx_valid = 1'b0;
            wait_done(base + 2);
            check("b2b_second", snap_rx, exp_word(32'hFFFF_FFFE, 1'b1));
            check("b2b_gap", 64'(last_gap), 64'd1);
            for (int i = 0; i < 3; i++) tk();
            check("b2b_no_third", 64'({busy, spi_en}), 64'b00);
        end

        start(32'hA5C3_0F81);
        for (int i = 0; i < 99; i++) tk();
        check("pre_reset_active", 64'({spi_en, busy}), 64'b11);
        nrst = 1'b0;
        #1;
        check("async_reset", 64'({tx_ready, spi_en, spi_clk, busy, done, spi_data}), 64'b100000);
        tk();
        tk();
        nrst = 1'b1;
        tk();
        begin
            int base;
            base = done_total;
            start(32'h1234_5678);
            wait_done(base + 1);
            check("after_reset_word", snap_rx, exp_word(32'h1234_5678, 1'b1));
            check("after_reset_len", 64'(snap_en), 64'(EN_LEN));
        end
        for (int i = 0; i < 3; i++) tk();

        begin
            int base;
            base = done_total;
            bad = 0;
            start(32'h3C3C_A5A5);
            tx_data = 32'hDEAD_BEEF;
            for (int i = 0; i < 200; i++) begin
                tx_valid = ~tx_valid;
                if (tx_ready) bad++;
                tk();
            end
            tx_valid = 1'b0;
            for (int i = 0; i < 3000 && !done; i++) begin
                if (tx_ready) bad++;
                tk();
            end
            check("ready_low_in_frame", 64'(bad), 64'd0);
            wait_done(base + 1);
            check("inflight_word", snap_rx, exp_word(32'h3C3C_A5A5, 1'b0));
            for (int i = 0; i < 3; i++) tk();
            check("no_extra_frame", 64'({busy, spi_en, tx_ready}), 64'b001);
        end

        check("data_stable_high", 64'(viol), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
